// File: rtl/run_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_seq_pkg
//  Description : Shared state encoding and default constants for the
//                run_sequencer program-sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package run_seq_pkg;

    // Sequencer states; every transition between them is registered.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CORE_RST = 3'd1,
        S_START    = 3'd2,
        S_RUN      = 3'd3,
        S_REPORT   = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    localparam int C_RST_CYCLES_DEF = 2;
    localparam int C_START_HOLD_DEF = 2;
    localparam int C_MAX_CYCLES_DEF = 10000;
    localparam int C_CNT_W_DEF      = 16;

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter
//  Description : Loadable, clearable, enabled up-counter with a terminal
//                compare output. Shared between phase timing and run-cycle
//                measurement in run_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    // Count register: clear beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == term);

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer
//  Description : Runs NUM_PROGS programs on an attached core: reset pulse,
//                start pulse, wait for done (or timeout), report, repeat.
//                Optional macro RUN_SEQ_STOP_ON_TIMEOUT_EN ends the whole
//                sequence after the first timed-out program.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int NUM_PROGS  = 3,
    parameter int RST_CYCLES = C_RST_CYCLES_DEF,
    parameter int START_HOLD = C_START_HOLD_DEF,
    parameter int MAX_CYCLES = C_MAX_CYCLES_DEF,
    parameter int CNT_W      = C_CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         abort,
    input  logic                         core_done,
    output logic                         core_reset,
    output logic                         core_start,
    output logic [$clog2(NUM_PROGS)-1:0] prog_sel,
    output logic                         busy,
    output logic                         result_valid,
    output logic [$clog2(NUM_PROGS)-1:0] result_prog,
    output logic [CNT_W-1:0]             result_cycles,
    output logic                         result_timeout,
    output logic                         all_done
);

    localparam int PW = $clog2(NUM_PROGS);

    localparam logic [CNT_W-1:0] C_RST_TERM   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_START_TERM = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] C_RUN_TERM   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [PW-1:0]    C_LAST_PROG  = PW'(NUM_PROGS - 1);

`ifdef RUN_SEQ_STOP_ON_TIMEOUT_EN
    localparam logic C_STOP_ON_TIMEOUT = 1'b1;
`else
    localparam logic C_STOP_ON_TIMEOUT = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic             r_abort_rst;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_term;
    logic [CNT_W-1:0] w_cnt;
    logic             w_at_term;
    logic             w_last;
    logic             w_run_end;

    seq_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (w_cnt_load),
        .load_val ('0),
        .en       (w_cnt_en),
        .term     (w_term),
        .count    (w_cnt),
        .at_term  (w_at_term)
    );

    assign w_last    = (prog_sel == C_LAST_PROG);
    // A run ends on done or timeout; abort suppresses it so nothing is reported.
    assign w_run_end = (r_state == S_RUN) && !abort && (core_done || w_at_term);

    // Terminal value for the phase currently being timed.
    always_comb begin
        w_term = C_RUN_TERM;
        case (r_state)
            S_CORE_RST: w_term = C_RST_TERM;
            S_START:    w_term = C_START_TERM;
            default:    w_term = C_RUN_TERM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and counter control; abort overrides every transition.
    always_comb begin
        w_next_state = r_state;
        w_cnt_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) w_next_state = S_CORE_RST;
            end
            S_CORE_RST: begin
                w_cnt_en = 1'b1;
                if (w_at_term) w_next_state = S_START;
            end
            S_START: begin
                w_cnt_en = 1'b1;
                if (w_at_term) w_next_state = S_RUN;
            end
            S_RUN: begin
                w_cnt_en = !core_done;
                if (core_done || w_at_term) w_next_state = S_REPORT;
            end
            S_REPORT: begin
                if (w_last || (C_STOP_ON_TIMEOUT && result_timeout)) w_next_state = S_FINISH;
                else                                                   w_next_state = S_CORE_RST;
            end
            S_FINISH: begin
                if (!go) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (abort) w_next_state = S_IDLE;
        // Every phase starts counting from zero.
        w_cnt_load = (w_next_state != r_state);
    end

    // Program index, abort-reset flag and held result fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_sel       <= '0;
            r_abort_rst    <= 1'b0;
            result_prog    <= '0;
            result_cycles  <= '0;
            result_timeout <= 1'b0;
        end else begin
            r_abort_rst <= abort;
            if (!abort) begin
                if (r_state == S_IDLE && go) begin
                    prog_sel <= '0;
                end else if (r_state == S_REPORT && !w_last) begin
                    prog_sel <= prog_sel + 1'b1;
                end
            end
            if (w_run_end) begin
                result_prog    <= prog_sel;
                result_cycles  <= w_cnt;
                result_timeout <= !core_done;
            end
        end
    end

    assign core_reset   = (r_state == S_CORE_RST) || r_abort_rst;
    assign core_start   = (r_state == S_START);
    assign busy         = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign result_valid = (r_state == S_REPORT);
    assign all_done     = (r_state == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_sequencer
//  Description : Self-checking bench for run_sequencer with a behavioural
//                core model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

    typedef struct packed {
        logic [1:0]  prog;
        logic [15:0] cyc;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        core_done = 1'b0;
    logic        core_reset;
    logic        core_start;
    logic [1:0]  prog_sel;
    logic        busy;
    logic        result_valid;
    logic [1:0]  result_prog;
    logic [15:0] result_cycles;
    logic        result_timeout;
    logic        all_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   tgt[4] = '{10, 10, 10, 10};
    bit   stale_en = 1'b0;
    int   run_cyc = -1;
    logic prev_start = 1'b0;
    int   rst_len = 0, start_len = 0, last_rst_len = 0, last_start_len = 0;

    run_sequencer #(
        .NUM_PROGS  (3),
        .RST_CYCLES (2),
        .START_HOLD (2),
        .MAX_CYCLES (100),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .abort          (abort),
        .core_done      (core_done),
        .core_reset     (core_reset),
        .core_start     (core_start),
        .prog_sel       (prog_sel),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_prog    (result_prog),
        .result_cycles  (result_cycles),
        .result_timeout (result_timeout),
        .all_done       (all_done)
    );

    always #5 clk = ~clk;

    // Core model: tracks RUN cycles from the falling edge of core_start and
    // raises done in the targeted cycle (optionally also while reset/start high).
    always @(posedge clk) begin
        #1;
        if (!busy || core_reset)              run_cyc = -1;
        else if (prev_start && !core_start)   run_cyc = 0;
        else if (run_cyc >= 0)                run_cyc = run_cyc + 1;
        prev_start = core_start;
        core_done = (stale_en && (core_reset || core_start)) ||
                    (run_cyc >= 0 && run_cyc == tgt[prog_sel]);
    end

    // Scoreboard consumer plus pulse-length monitor.
    always @(negedge clk) begin
        if (result_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got prog=%0d cycles=%0d timeout=%0b, expected none",
                         result_prog, result_cycles, result_timeout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({result_prog, result_cycles, result_timeout} !== {e.prog, e.cyc, e.to}) begin
                    n_bad++;
                    $display("FAIL result: got prog=%0d cycles=%0d timeout=%0b, expected prog=%0d cycles=%0d timeout=%0b",
                             result_prog, result_cycles, result_timeout, e.prog, e.cyc, e.to);
                end
            end
        end
        if (core_reset) rst_len++;
        else if (rst_len != 0) begin last_rst_len = rst_len; rst_len = 0; end
        if (core_start) start_len++;
        else if (start_len != 0) begin last_start_len = start_len; start_len = 0; end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int p, input int c, input bit t);
        exp_t e;
        e.prog = 2'(p);
        e.cyc  = 16'(c);
        e.to   = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_finish(input string name);
        for (int i = 0; i < 3000 && !all_done; i++) tick();
        n_cmp++;
        if (all_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_finish: all_done=%0b, expected 1 within bound", name, all_done);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_results: %0d results outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic release_go(input string name);
        go = 1'b0;
        for (int i = 0; i < 50 && (busy || all_done); i++) tick();
        n_cmp++;
        if (busy !== 1'b0 || all_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%0b all_done=%0b, expected 0/0", name, busy, all_done);
        end
    endtask

    task automatic wait_run(input int k, input string name);
        for (int i = 0; i < 300 && run_cyc != k; i++) tick();
        n_cmp++;
        if (run_cyc != k) begin
            n_bad++;
            $display("FAIL %s_reach_run: run cycle=%0d, expected %0d", name, run_cyc, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b1; abort = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({core_reset, core_start, prog_sel, busy, result_valid, result_prog,
             result_cycles, result_timeout, all_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rst=%0b start=%0b sel=%0d busy=%0b rv=%0b rp=%0d rc=%0d to=%0b done=%0b, expected all 0",
                     core_reset, core_start, prog_sel, busy, result_valid, result_prog,
                     result_cycles, result_timeout, all_done);
        end
        go = 1'b0; abort = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || core_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: busy=%0b core_reset=%0b, expected 0/0", busy, core_reset);
        end
    endtask

    task automatic test_three_progs();
        tgt = '{10, 10, 10, 10};
        push(0, 10, 0); push(1, 10, 0); push(2, 10, 0);
        go = 1'b1;
        wait_finish("three");
        n_cmp++;
        if (last_rst_len != 2) begin
            n_bad++;
            $display("FAIL core_reset_len: got %0d, expected 2", last_rst_len);
        end
        n_cmp++;
        if (last_start_len != 2) begin
            n_bad++;
            $display("FAIL core_start_len: got %0d, expected 2", last_start_len);
        end
        repeat (10) tick();
        n_cmp++;
        if (all_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL go_held_no_restart: all_done=%0b busy=%0b, expected 1/0", all_done, busy);
        end
        go = 1'b0;
        tick();
        n_cmp++;
        if (all_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL finish_to_idle: all_done=%0b busy=%0b, expected 0/0", all_done, busy);
        end
        push(0, 10, 0); push(1, 10, 0); push(2, 10, 0);
        go = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || prog_sel !== 2'd0 || core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL restart: busy=%0b prog_sel=%0d core_reset=%0b, expected 1/0/1", busy, prog_sel, core_reset);
        end
        wait_finish("restart");
        release_go("three");
    endtask

    task automatic test_timeout();
        tgt = '{10, -1, 10, 10};
        push(0, 10, 0);
        push(1, 99, 1);
`ifndef RUN_SEQ_STOP_ON_TIMEOUT_EN
        push(2, 10, 0);
`endif
        go = 1'b1;
        wait_finish("timeout");
        release_go("timeout");
    endtask

    task automatic test_stale_done();
        tgt = '{5, 5, 5, 5};
        stale_en = 1'b1;
        push(0, 5, 0); push(1, 5, 0); push(2, 5, 0);
        go = 1'b1;
        wait_finish("stale");
        stale_en = 1'b0;
        release_go("stale");
    endtask

    task automatic test_coincide();
        tgt = '{99, 3, 0, 0};
        push(0, 99, 0); push(1, 3, 0); push(2, 0, 0);
        go = 1'b1;
        wait_finish("coincide");
        release_go("coincide");
    endtask

    task automatic test_abort();
        tgt = '{50, 50, 50, 50};
        go = 1'b1;
        wait_run(3, "abort");
        abort = 1'b1; go = 1'b0;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || core_reset !== 1'b1 || core_start !== 1'b0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: busy=%0b core_reset=%0b core_start=%0b rv=%0b, expected 0/1/0/0",
                     busy, core_reset, core_start, result_valid);
        end
        tick();
        n_cmp++;
        if (core_reset !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pulse_len: core_reset=%0b busy=%0b, expected 0/0", core_reset, busy);
        end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_run();
        tgt = '{50, 50, 50, 50};
        go = 1'b1;
        wait_run(4, "midrst");
        reset = 1'b1; go = 1'b0;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (core_start !== 1'b0 || core_reset !== 1'b0 || busy !== 1'b0 ||
            prog_sel !== 2'd0 || result_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run: start=%0b rst=%0b busy=%0b sel=%0d rc=%0d, expected all 0",
                     core_start, core_reset, busy, prog_sel, result_cycles);
        end
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_three_progs();
        test_timeout();
        test_stale_done();
        test_coincide();
        test_abort();
        test_reset_mid_run();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
